pool_out_writer: RTL and testbench

- Downstream neighbour of the max-pool stage: consumes one pooled value per strobe and applies ReLU, then rounding requantisation to 8-bit unsigned.
- Packs four pooled bytes little-endian into 32-bit words and writes one output feature-map row per pool row finish into the on-chip output memory, through a small FIFO with a ready/write handshake.
- Signals frame completion once all rows have been written.

---
 rtl/pool_out_writer.sv | 178 +++++++++++++++++
 tb/tb_pool_out_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_out_writer.sv
// pool_out_writer: ReLU + rounding requantisation of pooled values, little-endian
// byte packing into 32-bit words, and row-addressed memory writes through a word FIFO.
module pool_out_writer #(
  parameter int N          = 7,
  parameter int OUT_W      = 14,
  parameter int ROWS       = 14,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*N+1:0]    in_data,
  input  logic              in_valid,
  input  logic              row_fin,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int DW  = 2*N + 2;
  localparam int WPR = (OUT_W + 3) / 4;
  localparam int CW  = $clog2(OUT_W + 1);
  localparam int RW  = $clog2(ROWS + 1);
  localparam int XW  = $clog2(WPR + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW:0]       OUT_W_C = (CW+1)'(OUT_W);
  localparam logic [RW-1:0]     ROWS_C  = RW'(ROWS);
  localparam logic [PW:0]       DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] WPR_C   = ADDR_W'(WPR);
  localparam logic [DW:0]       HALF_C  = (DW+1)'(2**(SHIFT-1));

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_ent_t;

  // stage 1: ReLU, round-half-up shift, saturate
  logic [DW-1:0] relu_x;
  logic [DW:0]   rnd_sum, q_full;
  logic [7:0]    q8;

  assign relu_x  = in_data[DW-1] ? '0 : in_data;
  assign rnd_sum = {1'b0, relu_x} + HALF_C;
  assign q_full  = rnd_sum >> SHIFT;
  assign q8      = (q_full > (DW+1)'(255)) ? 8'hFF : q_full[7:0];

  logic              s1_vld, fin_s1;
  logic [7:0]        s1_q;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [XW-1:0]     word_idx;
  logic [3:0][7:0]   pack;
  logic [3:0]        be;

  wr_ent_t           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       fifo_cnt;

  // A pending row_fin (fin_s1) means the row is closing: new samples and
  // row_fin pulses are judged against the row that follows it.
  logic [RW-1:0] row_eff;
  logic          row_open, accept, fin_take;

  assign row_eff  = fin_s1 ? row + RW'(1) : row;
  assign row_open = row_eff < ROWS_C;
  assign accept   = in_valid && row_open &&
                    (fin_s1 || (({1'b0, col} + (CW+1)'(s1_vld)) < OUT_W_C));
  assign fin_take = row_fin && row_open;

  // stage 2: byte lane merge and push decision
  logic [1:0]      lane;
  logic [3:0][7:0] pack_nxt;
  logic [3:0]      be_nxt;
  logic [CW-1:0]   col_inc;
  logic            word_end, push;
  wr_ent_t         push_ent;

  assign lane    = col[1:0];
  assign col_inc = col + CW'(1);

  always_comb begin
    pack_nxt = pack;
    be_nxt   = be;
    if (s1_vld) begin
      pack_nxt[lane] = s1_q;
      be_nxt[lane]   = 1'b1;
    end
  end

  assign word_end = s1_vld && (lane == 2'd3 || {1'b0, col_inc} == OUT_W_C);
  assign push     = (be_nxt != 4'd0) && (fin_s1 || word_end);
  assign push_ent = {ADDR_W'(row) * WPR_C + ADDR_W'(word_idx), pack_nxt, be_nxt};

  logic fifo_empty, fifo_full, pop, push_ok, drop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign pop        = !fifo_empty && mem_ready;
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      fin_s1   <= 1'b0;
      s1_q     <= '0;
      col      <= '0;
      row      <= '0;
      word_idx <= '0;
      pack     <= '0;
      be       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_vld <= accept;
      fin_s1 <= fin_take;
      if (accept) begin
        s1_q <= q8;
        busy <= 1'b1;
      end

      if (push) begin
        pack     <= '0;
        be       <= '0;
        word_idx <= word_idx + XW'(1);
      end else begin
        pack <= pack_nxt;
        be   <= be_nxt;
      end
      if (s1_vld) col <= col_inc;
      if (fin_s1) begin
        col      <= '0;
        word_idx <= '0;
        row      <= row + RW'(1);
      end

      // row == ROWS implies no stage-2 activity, so an empty FIFO is final
      done <= 1'b0;
      if (row == ROWS_C && fifo_empty) begin
        done <= 1'b1;
        busy <= 1'b0;
        row  <= '0;
      end

      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_ent;
  end

  wr_ent_t head;
  assign head      = fifo_mem[rd_ptr];
  assign mem_we    = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : head.addr;
  assign mem_wdata = fifo_empty ? '0 : head.data;
  assign mem_be    = fifo_empty ? '0 : head.be;

endmodule

// File: tb/tb_pool_out_writer.sv
// Bench for pool_out_writer: directed and randomised rows, scoreboarded against
// a per-row arithmetic model of quantise/pack/address.
module tb_pool_out_writer;
  localparam int N = 7, OUT_W = 14, ROWS = 14, SHIFT = 4, FD = 4, AW = 10;
  localparam int WPR = (OUT_W + 3) / 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, row_fin, mem_ready;
  logic [15:0]   in_data;
  logic          mem_we, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  pool_out_writer #(.N(N), .OUT_W(OUT_W), .ROWS(ROWS), .SHIFT(SHIFT),
                    .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .row_fin(row_fin), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .busy(busy), .done(done), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int be; } wr_t;
  wr_t exp_q[$];

  int  n_assert = 0, n_fail = 0;
  int  cyc = 0, wr_cnt = 0, last_addr = -1, last_wr_cyc = 0;
  bit  rnd_ready = 0;
  logic [15:0] vq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int quant(input logic [15:0] d);
    int x;
    x = int'($signed(d));
    if (x < 0) return 0;
    x = (x + 2**(SHIFT-1)) / 2**SHIFT;
    return (x > 255) ? 255 : x;
  endfunction

  // Expected writes for one row: first OUT_W samples, four per word, word-aligned rows
  task automatic model_row(input int r, input logic [15:0] vals[$]);
    int n;
    n = (vals.size() < OUT_W) ? vals.size() : OUT_W;
    for (int w = 0; w * 4 < n; w++) begin
      wr_t e;
      e.addr = r * WPR + w;
      e.data = 0;
      e.be   = 0;
      for (int l = 0; l < 4; l++)
        if (w * 4 + l < n) begin
          e.data |= quant(vals[w*4+l]) << (8 * l);
          e.be   |= 1 << l;
        end
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit f);
    in_valid = v;
    in_data  = d;
    row_fin  = f;
    if (rnd_ready) mem_ready = ($urandom_range(0, 7) != 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    row_fin  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic send_row(input int r, input logic [15:0] vals[$], input bit fin_with_last);
    model_row(r, vals);
    foreach (vals[i]) step(1'b1, vals[i], fin_with_last && (i == vals.size() - 1));
    if (!fin_with_last) step(1'b0, 16'h0, 1'b1);
  endtask

  task automatic gen_vals(input int n, output logic [15:0] v[$]);
    v = {};
    for (int i = 0; i < n; i++)
      case ($urandom_range(0, 3))
        0:       v.push_back(16'h8000 | 16'($urandom_range(0, 32767)));
        1:       v.push_back(16'($urandom_range(0, 300)));
        2:       v.push_back(16'($urandom_range(0, 4095)));
        default: v.push_back(16'($urandom_range(4070, 4100)));
      endcase
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit seen;
    seen = 0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_write_before"}, 32'(last_wr_cyc < cyc), 32'd1);
      @(negedge clk); #1;
      chk({tag, "_one_cycle"}, 32'(done), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  // write monitor / scoreboard
  initial forever begin
    wr_t e;
    @(negedge clk);
    cyc++;
    if (mem_we && mem_ready) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_be", 32'(mem_be), e.be);
      end
      wr_cnt++;
      last_addr   = int'(mem_addr);
      last_wr_cyc = cyc;
    end
    if (done) chk("done_vs_we", 32'(mem_we), 32'd0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; row_fin = 1'b0; in_data = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;

    // Frame A, row 0: quantise vectors and first-word latency
    vq = {16'h0123, 16'h1000, 16'hFF00, 16'h0007, 16'h0008};
    model_row(0, vq);
    step(1'b1, vq[0], 1'b0);
    chk("busy_rise", 32'(busy), 32'd1);
    step(1'b1, vq[1], 1'b0);
    step(1'b1, vq[2], 1'b0);
    step(1'b1, vq[3], 1'b0);
    @(negedge clk);
    chk("lat_stage1", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("lat_stage2", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    step(1'b1, vq[4], 1'b0);
    step(1'b0, 16'h0, 1'b1);

    // row 1: full row 1..14 (x16); row 2: short row
    vq = {};
    for (int k = 1; k <= OUT_W; k++) vq.push_back(16'(k * 16));
    send_row(1, vq, 1'b0);
    vq = {16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
    send_row(2, vq, 1'b0);

    // rows 3..12: random contents, lengths, row_fin alignment and backpressure
    rnd_ready = 1;
    for (int r = 3; r < ROWS - 1; r++) begin
      gen_vals($urandom_range(1, 16), vq);
      send_row(r, vq, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end
    rnd_ready = 0; mem_ready = 1'b1;
    idle(8);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_no_ovf", 32'(overflow), 32'd0);

    // last row held in the FIFO; samples after the final row_fin must be ignored
    mem_ready = 1'b0;
    gen_vals(OUT_W, vq);
    send_row(ROWS - 1, vq, 1'b0);
    repeat (4) step(1'b1, 16'h0100, 1'b0);
    idle(2);
    chk("post_frame_ignored", 32'(overflow), 32'd0);
    chk("busy_hold", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    wait_done("doneA", 40);

    // Frame B: 14 full rows, always ready
    wr_cnt = 0;
    for (int r = 0; r < ROWS; r++) begin
      gen_vals(OUT_W, vq);
      send_row(r, vq, 1'(r % 2 == 0));
    end
    chk("frameB_busy", 32'(busy), 32'd1);
    wait_done("doneB", 40);
    chk("frameB_writes", 32'(wr_cnt), 32'd56);
    chk("frameB_last_addr", 32'(last_addr), 32'd55);

    // Backpressure: four words fill the FIFO, the fifth is dropped
    mem_ready = 1'b0;
    gen_vals(OUT_W, vq);
    send_row(0, vq, 1'b0);
    chk("bp_ovf_before", 32'(overflow), 32'd0);
    chk("bp_head_addr", 32'(mem_addr), 32'd0);
    gen_vals(4, vq);
    foreach (vq[i]) step(1'b1, vq[i], 1'b0);
    idle(2);
    chk("bp_ovf_set", 32'(overflow), 32'd1);
    idle(16);
    chk("bp_still_held", 32'(mem_we), 32'd1);
    mem_ready = 1'b1;
    idle(6);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame with a word waiting
    mem_ready = 1'b0;
    gen_vals(6, vq);
    foreach (vq[i]) step(1'b1, vq[i], 1'b0);
    idle(2);
    chk("mid_we_before", 32'(mem_we), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    vq = {16'h0100, 16'h7FFF, 16'h8001};
    send_row(0, vq, 1'b0);
    idle(4);
    chk("restart_drained", 32'(exp_q.size()), 32'd0);
    chk("restart_addr", 32'(last_addr), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
